// File: rtl/pass_sequencer_if.sv
// Pass-level handshake and per-pass GLB base addresses between the layer
// sequencer (master) and Controller_pass (slave).
interface pass_sequencer_if #(
   parameter int ADDR_W = 32
);
   logic              pass_start;
   logic              pass_done;
   logic              bias_ipsum_sel;
   logic [ADDR_W-1:0] ifmap_baseaddr;
   logic [ADDR_W-1:0] filter_baseaddr;
   logic [ADDR_W-1:0] bias_baseaddr;
   logic [ADDR_W-1:0] opsum_baseaddr;

   modport master (
      output pass_start,
      output bias_ipsum_sel,
      output ifmap_baseaddr,
      output filter_baseaddr,
      output bias_baseaddr,
      output opsum_baseaddr,
      input  pass_done
   );

   modport slave (
      input  pass_start,
      input  bias_ipsum_sel,
      input  ifmap_baseaddr,
      input  filter_baseaddr,
      input  bias_baseaddr,
      input  opsum_baseaddr,
      output pass_done
   );
endinterface

// File: rtl/pass_sequencer.sv
// Layer-level pass sequencer: walks m (outer), e, c (inner) tiles, one pass at a time.
// Optional performance counters are enabled with the macro PASS_SEQ_PERF_EN.
module pass_sequencer #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  m_tiles,
   input  logic [CNT_W-1:0]  e_tiles,
   input  logic [CNT_W-1:0]  c_tiles,
   input  logic [ADDR_W-1:0] ifmap_base,
   input  logic [ADDR_W-1:0] filter_base,
   input  logic [ADDR_W-1:0] bias_base,
   input  logic [ADDR_W-1:0] opsum_base,
   input  logic [ADDR_W-1:0] ifmap_c_stride,
   input  logic [ADDR_W-1:0] ifmap_e_stride,
   input  logic [ADDR_W-1:0] filter_stride,
   input  logic [ADDR_W-1:0] bias_stride,
   input  logic [ADDR_W-1:0] opsum_stride,
   output logic              busy,
   output logic              done,
`ifdef PASS_SEQ_PERF_EN
   output logic [31:0]       perf_cycles,
   output logic [3*CNT_W-1:0] perf_passes,
`endif
   pass_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      ADVANCE = 3'd3,
      FIN     = 3'd4
   } state_t;

   state_t            state_r, state_n;
   logic              pass_start_r, busy_r, done_r;
   logic [CNT_W-1:0]  m_last_r, e_last_r, c_last_r;
   logic [CNT_W-1:0]  m_r, e_r, c_r;
   logic [ADDR_W-1:0] ifmap_base_r, ics_r, ies_r, fs_r, bs_r, os_r;
   logic [ADDR_W-1:0] ifmap_r, ifmap_row_r, filter_r, filter_mrow_r, bias_r, opsum_r;
   logic              accept_s, c_wrap_s, e_wrap_s, last_s;

   // Tile counts are stored as last index so a zero count behaves like one.
   function automatic logic [CNT_W-1:0] last_idx(input logic [CNT_W-1:0] tiles);
      return (tiles == '0) ? '0 : tiles - CNT_W'(1);
   endfunction

   assign accept_s = (state_r == IDLE) && start;
   assign c_wrap_s = (c_r == c_last_r);
   assign e_wrap_s = (e_r == e_last_r);
   assign last_s   = c_wrap_s && e_wrap_s && (m_r == m_last_r);

   // Next-state decode of the layer FSM.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE:    if (start) state_n = ISSUE; else state_n = IDLE;
         ISSUE:   state_n = WAIT;
         WAIT:    if (bus.pass_done) state_n = ADVANCE; else state_n = WAIT;
         ADVANCE: if (last_s) state_n = FIN; else state_n = ISSUE;
         FIN:     state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State register and registered control outputs decoded from the next state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         pass_start_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_n;
         pass_start_r <= (state_n == ISSUE);
         busy_r       <= (state_n == ISSUE) || (state_n == WAIT) || (state_n == ADVANCE);
         done_r       <= (state_n == FIN);
      end
   end

   // Config latch, loop counters and running base addresses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_last_r      <= '0;
         e_last_r      <= '0;
         c_last_r      <= '0;
         m_r           <= '0;
         e_r           <= '0;
         c_r           <= '0;
         ifmap_base_r  <= '0;
         ics_r         <= '0;
         ies_r         <= '0;
         fs_r          <= '0;
         bs_r          <= '0;
         os_r          <= '0;
         ifmap_r       <= '0;
         ifmap_row_r   <= '0;
         filter_r      <= '0;
         filter_mrow_r <= '0;
         bias_r        <= '0;
         opsum_r       <= '0;
      end else if (accept_s) begin
         m_last_r      <= last_idx(m_tiles);
         e_last_r      <= last_idx(e_tiles);
         c_last_r      <= last_idx(c_tiles);
         m_r           <= '0;
         e_r           <= '0;
         c_r           <= '0;
         ifmap_base_r  <= ifmap_base;
         ics_r         <= ifmap_c_stride;
         ies_r         <= ifmap_e_stride;
         fs_r          <= filter_stride;
         bs_r          <= bias_stride;
         os_r          <= opsum_stride;
         ifmap_r       <= ifmap_base;
         ifmap_row_r   <= ifmap_base;
         filter_r      <= filter_base;
         filter_mrow_r <= filter_base;
         bias_r        <= bias_base;
         opsum_r       <= opsum_base;
      end else if (state_r == ADVANCE) begin
         if (!c_wrap_s) begin
            c_r      <= c_r + CNT_W'(1);
            ifmap_r  <= ifmap_r + ics_r;
            filter_r <= filter_r + fs_r;
         end else if (!e_wrap_s) begin
            // Next output-row group: same filters, next ifmap row, next opsum tile.
            c_r         <= '0;
            e_r         <= e_r + CNT_W'(1);
            ifmap_row_r <= ifmap_row_r + ies_r;
            ifmap_r     <= ifmap_row_r + ies_r;
            filter_r    <= filter_mrow_r;
            opsum_r     <= opsum_r + os_r;
         end else begin
            // Filter tiles are contiguous per m, so the next m row starts right after this one.
            c_r           <= '0;
            e_r           <= '0;
            m_r           <= m_r + CNT_W'(1);
            bias_r        <= bias_r + bs_r;
            filter_r      <= filter_r + fs_r;
            filter_mrow_r <= filter_r + fs_r;
            opsum_r       <= opsum_r + os_r;
            ifmap_r       <= ifmap_base_r;
            ifmap_row_r   <= ifmap_base_r;
         end
      end
   end

`ifdef PASS_SEQ_PERF_EN
   logic [31:0]        perf_cycles_r;
   logic [3*CNT_W-1:0] perf_passes_r;

   // Busy-cycle and issued-pass counters, cleared on an accepted start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_cycles_r <= '0;
         perf_passes_r <= '0;
      end else if (accept_s) begin
         perf_cycles_r <= '0;
         perf_passes_r <= '0;
      end else begin
         if (busy_r) perf_cycles_r <= perf_cycles_r + 32'd1;
         if (pass_start_r) perf_passes_r <= perf_passes_r + (3*CNT_W)'(1);
      end
   end

   assign perf_cycles = perf_cycles_r;
   assign perf_passes = perf_passes_r;
`endif

   assign bus.pass_start      = pass_start_r;
   assign bus.bias_ipsum_sel  = (c_r != '0);
   assign bus.ifmap_baseaddr  = ifmap_r;
   assign bus.filter_baseaddr = filter_r;
   assign bus.bias_baseaddr   = bias_r;
   assign bus.opsum_baseaddr  = opsum_r;
   assign busy                = busy_r;
   assign done                = done_r;

endmodule

// File: tb/tb_pass_sequencer.sv
// Self-checking bench for pass_sequencer: directed layer table, interference
// sequences and random layers checked against a closed-form address model.
module tb_pass_sequencer;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 8;

   typedef struct {
      logic [CNT_W-1:0]  m, e, c;
      logic [ADDR_W-1:0] ib, fb, bb, ob;
      logic [ADDR_W-1:0] ics, ies, fs, bs, os;
      int                lat;
      bit                glitch;
      int                exp_passes;
      logic [ADDR_W-1:0] exp_last_f, exp_last_o;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [CNT_W-1:0]  m_tiles = '0, e_tiles = '0, c_tiles = '0;
   logic [ADDR_W-1:0] ifmap_base = '0, filter_base = '0, bias_base = '0, opsum_base = '0;
   logic [ADDR_W-1:0] ifmap_c_stride = '0, ifmap_e_stride = '0, filter_stride = '0;
   logic [ADDR_W-1:0] bias_stride = '0, opsum_stride = '0;
   logic              busy, done;
`ifdef PASS_SEQ_PERF_EN
   logic [31:0]        perf_cycles;
   logic [3*CNT_W-1:0] perf_passes;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cnt = 0;

   pass_sequencer_if #(.ADDR_W(ADDR_W)) pif ();

   pass_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .m_tiles(m_tiles), .e_tiles(e_tiles), .c_tiles(c_tiles),
      .ifmap_base(ifmap_base), .filter_base(filter_base),
      .bias_base(bias_base), .opsum_base(opsum_base),
      .ifmap_c_stride(ifmap_c_stride), .ifmap_e_stride(ifmap_e_stride),
      .filter_stride(filter_stride), .bias_stride(bias_stride),
      .opsum_stride(opsum_stride),
      .busy(busy), .done(done),
`ifdef PASS_SEQ_PERF_EN
      .perf_cycles(perf_cycles), .perf_passes(perf_passes),
`endif
      .bus(pif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
   endtask

   function automatic int tiles(input logic [CNT_W-1:0] t);
      return (t == '0) ? 1 : int'(t);
   endfunction

   // Closed-form address of pass p: 0=ifmap 1=filter 2=bias 3=opsum 4=sel.
   function automatic logic [ADDR_W-1:0] model(input vec_t v, input int p, input int which);
      int ct, et, cc, ee, mm;
      logic [ADDR_W-1:0] r;
      ct = tiles(v.c);
      et = tiles(v.e);
      cc = p % ct;
      ee = (p / ct) % et;
      mm = p / (ct * et);
      case (which)
         0:       r = v.ib + v.ies * ADDR_W'(ee) + v.ics * ADDR_W'(cc);
         1:       r = v.fb + v.fs * ADDR_W'(mm * ct + cc);
         2:       r = v.bb + v.bs * ADDR_W'(mm);
         3:       r = v.ob + v.os * ADDR_W'(mm * et + ee);
         default: r = (cc != 0) ? 32'd1 : 32'd0;
      endcase
      return r;
   endfunction

   task automatic chk_reset_outs(input string name);
      chk({name, "_ctrl"}, {60'd0, pif.pass_start, pif.bias_ipsum_sel, busy, done}, 64'd0);
      chk({name, "_addr"}, {32'd0, pif.ifmap_baseaddr | pif.filter_baseaddr |
                             pif.bias_baseaddr | pif.opsum_baseaddr}, 64'd0);
   endtask

   task automatic run_layer(input vec_t v, input int intf_pass, input int rst_pass,
                            output int passes, output logic [ADDR_W-1:0] last_f,
                            output logic [ADDR_W-1:0] last_o);
      int total;
      total  = tiles(v.m) * tiles(v.e) * tiles(v.c);
      passes = 0;
      last_f = '0;
      last_o = '0;
      m_tiles = v.m; e_tiles = v.e; c_tiles = v.c;
      ifmap_base = v.ib; filter_base = v.fb; bias_base = v.bb; opsum_base = v.ob;
      ifmap_c_stride = v.ics; ifmap_e_stride = v.ies; filter_stride = v.fs;
      bias_stride = v.bs; opsum_stride = v.os;
      start = 1'b1;
      busy_cnt = 0;
      tick();
      start = 1'b0;
      for (int p = 0; p < total; p++) begin
         chk("pass_start", {63'd0, pif.pass_start}, 64'd1);
         chk("busy", {63'd0, busy}, 64'd1);
         chk("ifmap_addr", {32'd0, pif.ifmap_baseaddr}, {32'd0, model(v, p, 0)});
         chk("filter_addr", {32'd0, pif.filter_baseaddr}, {32'd0, model(v, p, 1)});
         chk("bias_addr", {32'd0, pif.bias_baseaddr}, {32'd0, model(v, p, 2)});
         chk("opsum_addr", {32'd0, pif.opsum_baseaddr}, {32'd0, model(v, p, 3)});
         chk("sel", {63'd0, pif.bias_ipsum_sel}, {32'd0, model(v, p, 4)});
         passes++;
         last_f = pif.filter_baseaddr;
         last_o = pif.opsum_baseaddr;
         if (v.glitch) pif.pass_done = 1'b1;
         tick();
         pif.pass_done = 1'b0;
         chk("pulse_width", {63'd0, pif.pass_start}, 64'd0);
         for (int k = 1; k < v.lat; k++) tick();
         chk("hold_filter", {32'd0, pif.filter_baseaddr}, {32'd0, model(v, p, 1)});
         chk("hold_ifmap", {32'd0, pif.ifmap_baseaddr}, {32'd0, model(v, p, 0)});
         if (p == intf_pass) begin
            start = 1'b1;
            m_tiles = 8'hff; c_tiles = 8'h05;
            ifmap_base = ~v.ib; filter_base = ~v.fb; bias_base = ~v.bb; opsum_base = ~v.ob;
            ifmap_c_stride = 32'h7; filter_stride = 32'h3; opsum_stride = 32'h9;
            tick();
            start = 1'b0;
            chk("start_ignored_busy", {63'd0, busy}, 64'd1);
            chk("start_ignored_issue", {63'd0, pif.pass_start}, 64'd0);
            chk("start_ignored_addr", {32'd0, pif.filter_baseaddr}, {32'd0, model(v, p, 1)});
         end
         if (p == rst_pass) begin
            rst = 1'b0;
            #1;
            chk_reset_outs("rst_mid");
            tick();
            tick();
            chk("rst_no_done", {61'd0, done, busy, pif.pass_start}, 64'd0);
            rst = 1'b1;
            return;
         end
         pif.pass_done = 1'b1;
         tick();
         pif.pass_done = 1'b0;
         chk("advance_quiet", {62'd0, pif.pass_start, done}, 64'd0);
         tick();
         if (p == total - 1) begin
            chk("done_pulse", {63'd0, done}, 64'd1);
            chk("busy_fin", {62'd0, busy, pif.pass_start}, 64'd0);
`ifdef PASS_SEQ_PERF_EN
            chk("perf_passes", {40'd0, perf_passes}, 64'(total));
            chk("perf_cycles", {32'd0, perf_cycles}, 64'(busy_cnt));
`endif
            tick();
            chk("done_width", {63'd0, done}, 64'd0);
`ifdef PASS_SEQ_PERF_EN
            chk("perf_hold", {32'd0, perf_cycles}, 64'(busy_cnt));
`endif
         end
      end
   endtask

   vec_t              tbl[4];
   vec_t              rv;
   int                passes;
   logic [ADDR_W-1:0] lf, lo;

   initial begin
      pif.pass_done = 1'b0;
      repeat (3) tick();
      chk_reset_outs("in_reset");
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         pif.pass_done = (i % 3 == 1);
         tick();
         chk_reset_outs("idle");
      end
      pif.pass_done = 1'b0;

      tbl[0] = '{8'd1, 8'd1, 8'd1, 32'h0, 32'h100, 32'h200, 32'h300,
                 32'h10, 32'h10, 32'h10, 32'h10, 32'h10, 5, 1'b0, 1, 32'h100, 32'h300};
      tbl[1] = '{8'd2, 8'd2, 8'd3, 32'h0, 32'h100, 32'h200, 32'h300,
                 32'h10, 32'h40, 32'h8, 32'h4, 32'h20, 5, 1'b0, 12, 32'h128, 32'h360};
      tbl[2] = '{8'd1, 8'd1, 8'd0, 32'h0, 32'h100, 32'h200, 32'h300,
                 32'h10, 32'h40, 32'h8, 32'h4, 32'h20, 3, 1'b1, 1, 32'h100, 32'h300};
      tbl[3] = '{8'd0, 8'd3, 8'd1, 32'h5000, 32'h1000, 32'h800, 32'h2000,
                 32'h4, 32'h80, 32'h10, 32'h8, 32'h100, 1, 1'b0, 3, 32'h1000, 32'h2200};

      for (int t = 0; t < 4; t++) begin
         run_layer(tbl[t], -1, -1, passes, lf, lo);
         chk($sformatf("tbl%0d_passes", t), 64'(passes), 64'(tbl[t].exp_passes));
         chk($sformatf("tbl%0d_last_filter", t), {32'd0, lf}, {32'd0, tbl[t].exp_last_f});
         chk($sformatf("tbl%0d_last_opsum", t), {32'd0, lo}, {32'd0, tbl[t].exp_last_o});
      end

      run_layer(tbl[1], 0, -1, passes, lf, lo);
      chk("intf_passes", 64'(passes), 64'd12);

      run_layer(tbl[1], -1, 2, passes, lf, lo);
      chk("rst_abort_passes", 64'(passes), 64'd3);
      tick();
      chk_reset_outs("after_rst");
      run_layer(tbl[1], -1, -1, passes, lf, lo);
      chk("restart_passes", 64'(passes), 64'd12);

      for (int r = 0; r < 8; r++) begin
         rv.m = CNT_W'($urandom_range(0, 3));
         rv.e = CNT_W'($urandom_range(0, 3));
         rv.c = CNT_W'($urandom_range(0, 3));
         rv.ib = $urandom; rv.fb = $urandom; rv.bb = $urandom; rv.ob = $urandom;
         rv.ics = $urandom; rv.ies = $urandom; rv.fs = $urandom;
         rv.bs = $urandom; rv.os = $urandom;
         rv.lat = int'($urandom_range(1, 6));
         rv.glitch = 1'($urandom_range(0, 1));
         rv.exp_passes = tiles(rv.m) * tiles(rv.e) * tiles(rv.c);
         rv.exp_last_f = '0;
         rv.exp_last_o = '0;
         run_layer(rv, -1, -1, passes, lf, lo);
         chk($sformatf("rand%0d_passes", r), 64'(passes), 64'(rv.exp_passes));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
